dec_gray: RTL and testbench

DEC_GRAY -- requirements
Module: dec_gray

---
 rtl/dec_gray.sv | 82 ++++++++
 tb/tb_dec_gray.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dec_gray.sv
// Gray-code position decoder: combinational one-hot and binary decode, plus a
// registered copy that classifies each sampled move as up, down or illegal.
module dec_gray #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in,
  output logic [(2**N)-1:0] out,
  output logic [N-1:0]      bin,
  output logic [(2**N)-1:0] out_q,
  output logic [N-1:0]      bin_q,
  output logic              valid_q,
  output logic              step_up,
  output logic              step_dn,
  output logic              step_err,
  output logic              err_sticky
);

  localparam int W = 2**N;
  localparam logic [N-1:0] DIFF_UP = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] DIFF_DN = {N{1'b1}};

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when more than one bit of x is set.
  function automatic logic multi_bit(input logic [N-1:0] x);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {3'b000, x[i]};
    end
    return cnt > 4'd1;
  endfunction

  logic [N-1:0] diff_s;
  logic         err_s;
  logic         acc_s;

  // Binary decode: running XOR of the Gray bits from the MSB downwards.
  always_comb begin
    bin   = {N{1'b0}};
    acc_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      acc_s  = acc_s ^ in[i];
      bin[i] = acc_s;
    end
  end

  // One-hot position decode.
  always_comb begin
    out      = {W{1'b0}};
    out[bin] = 1'b1;
  end

  assign diff_s = bin - bin_q;
  assign err_s  = valid_q & multi_bit(in ^ to_gray(bin_q));

  // Sample registers and step classification; pulses need a prior sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= {W{1'b0}};
      bin_q      <= {N{1'b0}};
      valid_q    <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_q      <= out;
      bin_q      <= bin;
      valid_q    <= 1'b1;
      step_up    <= valid_q & (diff_s == DIFF_UP);
      step_dn    <= valid_q & (diff_s == DIFF_DN);
      step_err   <= err_s;
      err_sticky <= err_sticky | err_s;
    end
  end

endmodule

// File: tb/tb_dec_gray.sv
// Randomised self-checking bench for dec_gray against a position-level model.
module tb_dec_gray;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in  = 3'b000;
  logic [W-1:0] out, out_q;
  logic [N-1:0] bin, bin_q;
  logic         valid_q, step_up, step_dn, step_err, err_sticky;

  int total = 0;
  int bad   = 0;

  // model state
  int           m_pos     = 0;
  logic [N-1:0] m_prev_in = 3'b000;
  logic         m_valid   = 1'b0;
  logic         m_up      = 1'b0;
  logic         m_dn      = 1'b0;
  logic         m_err     = 1'b0;
  logic         m_sticky  = 1'b0;

  dec_gray #(.N(N)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .bin(bin),
    .out_q(out_q), .bin_q(bin_q), .valid_q(valid_q),
    .step_up(step_up), .step_dn(step_dn), .step_err(step_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Position of a Gray code word: the index whose reflected code matches it.
  function automatic int gray_pos(input logic [N-1:0] g);
    int p;
    p = 0;
    for (int k = 0; k < W; k++) begin
      if (((k ^ (k >> 1)) & (W - 1)) == int'(g)) p = k;
    end
    return p;
  endfunction

  // Drive one cycle: check combinational decode, clock, check registers.
  task automatic cyc(input logic [N-1:0] g, input logic r);
    int k, d;
    in  = g;
    rst = r;
    #2;
    k = gray_pos(g);
    check("out", 64'(out), 64'(1) << k);
    check("bin", 64'(bin), 64'(k));
    if (r) begin
      m_valid = 1'b0; m_pos = 0; m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
    end else begin
      if (m_valid) begin
        d     = (k - m_pos + W) % W;
        m_up  = (d == 1);
        m_dn  = (d == W - 1);
        m_err = ($countones(g ^ m_prev_in) > 1);
      end else begin
        m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      end
      m_sticky  = m_sticky | m_err;
      m_pos     = k;
      m_prev_in = g;
      m_valid   = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_q",      64'(out_q),      m_valid ? (64'(1) << m_pos) : 64'(0));
    check("bin_q",      64'(bin_q),      64'(m_pos));
    check("valid_q",    64'(valid_q),    64'(m_valid));
    check("step_up",    64'(step_up),    64'(m_up));
    check("step_dn",    64'(step_dn),    64'(m_dn));
    check("step_err",   64'(step_err),   64'(m_err));
    check("err_sticky", 64'(err_sticky), 64'(m_sticky));
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] g;
    int           mode;

    // reset held two edges with in=110
    cyc(3'b110, 1'b1);
    cyc(3'b110, 1'b1);
    check("rst_out_imm", 64'(out), 64'h10);
    check("rst_valid", 64'(valid_q), 64'd0);

    // full Gray sweep
    cyc(3'b000, 1'b0); cyc(3'b001, 1'b0); cyc(3'b011, 1'b0); cyc(3'b010, 1'b0);
    cyc(3'b110, 1'b0); cyc(3'b111, 1'b0); cyc(3'b101, 1'b0); cyc(3'b100, 1'b0);

    // first edges after reset, then two up steps
    cyc(3'b000, 1'b1);
    cyc(3'b000, 1'b0);
    check("first_no_up", 64'(step_up), 64'd0);
    cyc(3'b001, 1'b0);
    cyc(3'b011, 1'b0);
    check("up_twice", 64'(step_up), 64'd1);
    check("bin_q_2", 64'(bin_q), 64'd2);
    check("out_q_04", 64'(out_q), 64'h04);

    // wrap up then wrap down
    cyc(3'b100, 1'b0);
    cyc(3'b000, 1'b0);
    check("wrap_up", 64'(step_up), 64'd1);
    cyc(3'b100, 1'b0);
    check("wrap_dn", 64'(step_dn), 64'd1);

    // hold: no pulses
    cyc(3'b100, 1'b0);

    // illegal jump, sticky held through legal steps
    cyc(3'b000, 1'b0);
    cyc(3'b011, 1'b0);
    check("err_pulse", 64'(step_err), 64'd1);
    cyc(3'b010, 1'b0);
    check("err_one_cycle", 64'(step_err), 64'd0);
    check("err_held", 64'(err_sticky), 64'd1);
    cyc(3'b110, 1'b0);

    // reset mid-sequence, then 111
    cyc(3'b011, 1'b1);
    cyc(3'b111, 1'b0);
    check("post_rst_nopulse", 64'(step_up | step_dn | step_err), 64'd0);
    check("post_rst_bin_q", 64'(bin_q), 64'd5);
    check("post_rst_sticky", 64'(err_sticky), 64'd0);

    // randomised walk: mostly legal steps, some holds, jumps and resets
    cur = 3'd5;
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0, 1, 2: cur = cur + 3'd1;
        3, 4, 5: cur = cur - 3'd1;
        6:       cur = cur;
        default: cur = 3'($urandom_range(0, W - 1));
      endcase
      g = cur ^ (cur >> 1);
      cyc(g, ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
